// File: rtl/mem_port_arbiter.sv
// Shares the OTTER_mem_byte data port between I-cache line refill bursts and MEM-stage loads/stores.
// Optional build macro CRIT_WORD_FIRST_EN: refill starts at the missed word and wraps around the line.
module mem_port_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          IC_REQ,
    input  logic [ADDR_W-1:0]             IC_ADDR,
    output logic [DATA_W-1:0]             IC_WDATA,
    output logic [$clog2(LINE_WORDS)-1:0] IC_WIDX,
    output logic                          IC_WVALID,
    output logic                          IC_DONE,
    input  logic                          D_REQ,
    input  logic                          D_WE,
    input  logic [ADDR_W-1:0]             D_ADDR,
    input  logic [DATA_W-1:0]             D_WDATA,
    input  logic [1:0]                    D_SIZE,
    input  logic                          D_SIGN,
    output logic [DATA_W-1:0]             D_RDATA,
    output logic                          D_ACK,
    output logic                          D_STALL,
    output logic                          BUSY,
    output logic                          MEM_RE,
    output logic                          MEM_WE,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic [DATA_W-1:0]             MEM_DIN,
    output logic [1:0]                    MEM_SIZE,
    output logic                          MEM_SIGN,
    input  logic [DATA_W-1:0]             MEM_DOUT
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [IDX_W-1:0]  LAST_CNT  = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        D_ISSUE,
        D_RESP,
        F_ISSUE,
        F_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic              d_we_p0;
    logic [ADDR_W-1:0] d_addr_p0;
    logic [DATA_W-1:0] d_wdata_p0;
    logic [1:0]        d_size_p0;
    logic              d_sign_p0;

    logic [ADDR_W-1:0] base_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [IDX_W-1:0]  cnt_p0;
    logic [IDX_W-1:0]  widx_p1;

    logic [IDX_W-1:0]  start_idx;
    logic [ADDR_W-1:0] idx_off;

`ifdef CRIT_WORD_FIRST_EN
    assign start_idx = IC_ADDR[IDX_W+1:2];
`else
    assign start_idx = '0;
`endif

    assign idx_off = {{(ADDR_W-IDX_W-2){1'b0}}, idx_p0, 2'b00};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            d_we_p0    <= 1'b0;
            d_addr_p0  <= '0;
            d_wdata_p0 <= '0;
            d_size_p0  <= '0;
            d_sign_p0  <= 1'b0;
            base_p0    <= '0;
            idx_p0     <= '0;
            cnt_p0     <= '0;
            widx_p1    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (D_REQ) begin
                        d_we_p0    <= D_WE;
                        d_addr_p0  <= D_ADDR;
                        d_wdata_p0 <= D_WDATA;
                        d_size_p0  <= D_SIZE;
                        d_sign_p0  <= D_SIGN;
                    end else if (IC_REQ) begin
                        base_p0 <= IC_ADDR & ~LINE_MASK;
                        idx_p0  <= start_idx;
                        cnt_p0  <= '0;
                    end
                end
                // issue stage -> response stage: the issued index trails by one cycle with the read data
                F_ISSUE: begin
                    idx_p0  <= idx_p0 + IDX_W'(1);
                    cnt_p0  <= cnt_p0 + IDX_W'(1);
                    widx_p1 <= idx_p0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        IC_WDATA  = '0;
        IC_WIDX   = '0;
        IC_WVALID = 1'b0;
        IC_DONE   = 1'b0;
        D_RDATA   = '0;
        D_ACK     = 1'b0;
        MEM_RE    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_DIN   = '0;
        MEM_SIZE  = 2'b00;
        MEM_SIGN  = 1'b0;
        case (state)
            IDLE: begin
                if (D_REQ)       state_nxt = D_ISSUE;
                else if (IC_REQ) state_nxt = F_ISSUE;
            end
            D_ISSUE: begin
                MEM_ADDR  = d_addr_p0;
                MEM_RE    = ~d_we_p0;
                MEM_WE    = d_we_p0;
                MEM_DIN   = d_wdata_p0;
                MEM_SIZE  = d_size_p0;
                MEM_SIGN  = d_sign_p0;
                state_nxt = D_RESP;
            end
            D_RESP: begin
                D_ACK     = 1'b1;
                D_RDATA   = MEM_DOUT;
                state_nxt = IDLE;
            end
            F_ISSUE: begin
                MEM_RE   = 1'b1;
                MEM_SIZE = 2'b10;
                MEM_ADDR = base_p0 + idx_off;
                // the first issue has no returning word yet
                if (cnt_p0 != '0) begin
                    IC_WVALID = 1'b1;
                    IC_WIDX   = widx_p1;
                    IC_WDATA  = MEM_DOUT;
                end
                if (cnt_p0 == LAST_CNT) state_nxt = F_DRAIN;
            end
            F_DRAIN: begin
                IC_WVALID = 1'b1;
                IC_WIDX   = widx_p1;
                IC_WDATA  = MEM_DOUT;
                IC_DONE   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY    = (state != IDLE);
    assign D_STALL = D_REQ & ~D_ACK & RST_N;

endmodule
